// File: rtl/qpu_ifu_fetch_ctrl.sv
// IFU fetch sequencer: one outstanding instruction-memory request, one-entry decoder buffer.
// Optional macro QPU_IFU_BPU_EN: follow lite-BPU taken predictions (op1+op2) for the next PC.
module qpu_ifu_fetch_ctrl #(
  parameter int unsigned             PC_SIZE  = 32'd32,
  parameter logic [PC_SIZE-1:0]      RESET_PC = PC_SIZE'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  output logic [PC_SIZE-1:0] bpu_pc,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [PC_SIZE-1:0] ifu_o_pc,
  output logic [31:0]        ifu_o_instr,
  output logic               ifu_o_prdt_taken,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_ack
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]         state_r;
  logic [0:0]         state_nxt_s;
  logic [PC_SIZE-1:0] fetch_pc_r;
  logic [PC_SIZE-1:0] fetch_pc_nxt_s;
  logic [PC_SIZE-1:0] inflight_pc_r;
  logic [PC_SIZE-1:0] seq_pc_s;
  logic [PC_SIZE-1:0] next_pc_s;
  logic               drop_r;
  logic               drop_nxt_s;
  logic               o_valid_r;
  logic               o_valid_nxt_s;
  logic [PC_SIZE-1:0] o_pc_r;
  logic [31:0]        o_instr_r;
  logic               in_req_s;
  logic               in_wait_s;
  logic               req_fire_s;
  logic               rsp_fire_s;
  logic               o_fire_s;
  logic               load_s;

  assign in_req_s   = (state_r == ST_REQ);
  assign in_wait_s  = (state_r == ST_WAIT);

  assign ifu_req_valid  = in_req_s & ~rst;
  assign ifu_req_pc     = fetch_pc_r;
  assign bpu_pc         = inflight_pc_r;
  // A discarded response never needs buffer space.
  assign ifu_rsp_ready  = in_wait_s & ~rst & (drop_r | ~o_valid_r | ifu_o_ready);
  assign pipe_flush_ack = 1'b1;

  assign req_fire_s = ifu_req_valid & ifu_req_ready;
  assign rsp_fire_s = ifu_rsp_valid & ifu_rsp_ready;
  assign o_fire_s   = o_valid_r & ifu_o_ready;
  assign load_s     = rsp_fire_s & ~drop_r & ~pipe_flush_req;

  assign seq_pc_s = inflight_pc_r + PC_SIZE'(3'd4);

`ifdef QPU_IFU_BPU_EN
  logic [PC_SIZE-1:0] pred_pc_s;
  logic               o_prdt_taken_r;

  assign pred_pc_s        = prdt_pc_add_op1 + prdt_pc_add_op2;
  assign next_pc_s        = prdt_taken ? pred_pc_s : seq_pc_s;
  assign ifu_o_prdt_taken = o_prdt_taken_r;

  // Prediction recorded alongside the buffered instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      o_prdt_taken_r <= 1'b0;
    end else if (load_s) begin
      o_prdt_taken_r <= prdt_taken;
    end else begin
      o_prdt_taken_r <= o_prdt_taken_r;
    end
  end
`else
  logic unused_prdt_s;

  assign unused_prdt_s    = ^{prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2};
  assign next_pc_s        = seq_pc_s;
  assign ifu_o_prdt_taken = 1'b0;
`endif

  // Flush target beats both prediction and sequential next PC.
  assign fetch_pc_nxt_s = pipe_flush_req                          ? pipe_flush_pc :
                          (in_wait_s & rsp_fire_s & ~drop_r)      ? next_pc_s     :
                                                                    fetch_pc_r;

  // Sequencer next state and pending-discard flag
  always_comb begin
    state_nxt_s = state_r;
    drop_nxt_s  = drop_r;
    case (state_r)
      ST_REQ: begin
        if (req_fire_s) begin
          state_nxt_s = ST_WAIT;
          drop_nxt_s  = pipe_flush_req;
        end else begin
          state_nxt_s = ST_REQ;
          drop_nxt_s  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (rsp_fire_s) begin
          state_nxt_s = ST_REQ;
          drop_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_WAIT;
          drop_nxt_s  = drop_r | pipe_flush_req;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
        drop_nxt_s  = 1'b0;
      end
    endcase
  end

  // Buffer valid: flush clears, load wins over a same-cycle consume
  always_comb begin
    o_valid_nxt_s = o_valid_r;
    if (pipe_flush_req) begin
      o_valid_nxt_s = 1'b0;
    end else if (load_s) begin
      o_valid_nxt_s = 1'b1;
    end else if (o_fire_s) begin
      o_valid_nxt_s = 1'b0;
    end else begin
      o_valid_nxt_s = o_valid_r;
    end
  end

  // Sequencer state, fetch PC, in-flight PC and discard flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_REQ;
      fetch_pc_r    <= RESET_PC;
      inflight_pc_r <= {PC_SIZE{1'b0}};
      drop_r        <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      drop_r     <= drop_nxt_s;
      if (req_fire_s) begin
        inflight_pc_r <= fetch_pc_r;
      end else begin
        inflight_pc_r <= inflight_pc_r;
      end
    end
  end

  // Decoder-facing buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_r <= 1'b0;
      o_pc_r    <= {PC_SIZE{1'b0}};
      o_instr_r <= 32'h0000_0000;
    end else begin
      o_valid_r <= o_valid_nxt_s;
      if (load_s) begin
        o_pc_r    <= inflight_pc_r;
        o_instr_r <= ifu_rsp_instr;
      end else begin
        o_pc_r    <= o_pc_r;
        o_instr_r <= o_instr_r;
      end
    end
  end

  assign ifu_o_valid = o_valid_r;
  assign ifu_o_pc    = o_pc_r;
  assign ifu_o_instr = o_instr_r;

endmodule

// File: tb/tb_qpu_ifu_fetch_ctrl.sv
// Bench for qpu_ifu_fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (expected next PC, discard flag, expected buffer queue).
module tb_qpu_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid = 1'b0, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr = 32'h0;
  logic [31:0] bpu_pc;
  logic        prdt_taken = 1'b0;
  logic [31:0] prdt_pc_add_op1 = 32'h0, prdt_pc_add_op2 = 32'h0;
  logic        ifu_o_valid, ifu_o_ready = 1'b0;
  logic [31:0] ifu_o_pc, ifu_o_instr;
  logic        ifu_o_prdt_taken;
  logic        pipe_flush_req = 1'b0;
  logic [31:0] pipe_flush_pc = 32'h0;
  logic        pipe_flush_ack;

  qpu_ifu_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .bpu_pc(bpu_pc), .prdt_taken(prdt_taken),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_pc(ifu_o_pc),
    .ifu_o_instr(ifu_o_instr), .ifu_o_prdt_taken(ifu_o_prdt_taken),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus knobs
  bit          k_rst = 1'b1, k_req_ready = 1'b1, k_o_ready = 1'b1, k_flush = 1'b0, k_taken = 1'b0;
  logic [31:0] k_flush_pc = 32'h0, k_op1 = 32'h0, k_op2 = 32'h0;
  int          k_rsp_delay = 0;

  // memory responder
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_pc = 32'h0, mem_instr = 32'h0;

  // reference model
  bit          m_out = 1'b0, m_doomed = 1'b0;
  logic [31:0] m_next_pc = RST_PC;
  ent_t        q[$];

  // per-cycle observations and expectations
  logic        g_req_valid, g_req_fire, g_rsp_valid, g_rsp_ready, g_rsp_fire;
  logic        g_o_valid, g_o_fire, g_o_taken, g_ack;
  logic [31:0] g_req_pc, g_o_pc, g_o_instr, g_bpu_pc;
  logic        e_req_valid, e_rsp_ready, e_o_valid;
  logic [31:0] e_req_pc, e_bpu_pc;
  ent_t        e_o;

  task automatic tick();
    logic taken_eff;
    ent_t ent;
    @(negedge clk);
    rst             = k_rst;
    ifu_req_ready   = k_req_ready;
    ifu_o_ready     = k_o_ready;
    pipe_flush_req  = k_flush;
    pipe_flush_pc   = k_flush_pc;
    ifu_rsp_valid   = mem_busy && (mem_wait == 0);
    ifu_rsp_instr   = mem_instr;
    prdt_taken      = k_taken;
    prdt_pc_add_op1 = k_op1;
    prdt_pc_add_op2 = k_op2;
    #1;
    g_req_valid = ifu_req_valid;  g_req_pc    = ifu_req_pc;
    g_rsp_valid = ifu_rsp_valid;  g_rsp_ready = ifu_rsp_ready;
    g_o_valid   = ifu_o_valid;    g_o_pc      = ifu_o_pc;
    g_o_instr   = ifu_o_instr;    g_o_taken   = ifu_o_prdt_taken;
    g_bpu_pc    = bpu_pc;         g_ack       = pipe_flush_ack;
    g_req_fire  = ifu_req_valid && ifu_req_ready;
    g_rsp_fire  = ifu_rsp_valid && ifu_rsp_ready;
    g_o_fire    = ifu_o_valid && ifu_o_ready;
    e_req_valid = !k_rst && !m_out;
    e_req_pc    = m_next_pc;
    e_rsp_ready = !k_rst && m_out && (m_doomed || q.size() == 0 || k_o_ready);
    e_o_valid   = (q.size() != 0);
    e_o         = (q.size() != 0) ? q[0] : '0;
    e_bpu_pc    = mem_pc;
`ifdef QPU_IFU_BPU_EN
    taken_eff = k_taken;
`else
    taken_eff = 1'b0;
`endif
    if (k_rst) begin
      mem_busy = 1'b0; mem_wait = 0;
      m_out = 1'b0; m_doomed = 1'b0; m_next_pc = RST_PC;
      q.delete();
    end else begin
      if (g_o_fire && q.size() != 0) void'(q.pop_front());
      if (g_rsp_fire) begin
        mem_busy = 1'b0;
        m_out    = 1'b0;
        if (!m_doomed && !k_flush) begin
          ent = '{pc: mem_pc, instr: mem_instr, taken: taken_eff};
          q.push_back(ent);
          m_next_pc = taken_eff ? (k_op1 + k_op2) : (mem_pc + 32'd4);
        end
        m_doomed = 1'b0;
      end else if (mem_busy && mem_wait > 0) begin
        mem_wait--;
      end
      if (g_req_fire) begin
        mem_busy = 1'b1; mem_pc = g_req_pc; mem_wait = k_rsp_delay; mem_instr = $urandom;
        m_out = 1'b1; m_doomed = 1'b0;
      end
      if (k_flush) begin
        q.delete();
        m_next_pc = k_flush_pc;
        if (m_out) m_doomed = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    k_rst = 1'b1; k_flush = 1'b0; k_taken = 1'b0; k_req_ready = 1'b1; k_o_ready = 1'b1;
    k_rsp_delay = 0; k_op1 = 32'h0; k_op2 = 32'h0;
    tick(); tick();
    k_rst = 1'b0;
  endtask

  task automatic test_reset();
    k_rst = 1'b1;
    tick();
    n_checks++; if (g_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", g_req_valid); end
    n_checks++; if (g_rsp_ready !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_ready: got %b expected 0", g_rsp_ready); end
    tick();
    n_checks++; if ({g_o_valid, g_o_pc, g_o_instr, g_o_taken} !== 66'h0)
      begin n_errors++; $display("FAIL reset_buffer: got v=%b pc=%h i=%h t=%b expected all 0", g_o_valid, g_o_pc, g_o_instr, g_o_taken); end
    k_rst = 1'b0;
    tick();
    n_checks++; if (g_req_valid !== 1'b1 || g_req_pc !== RST_PC)
      begin n_errors++; $display("FAIL reset_first_req: got v=%b pc=%h expected 1/%h", g_req_valid, g_req_pc, RST_PC); end
    n_checks++; if (g_ack !== 1'b1) begin n_errors++; $display("FAIL flush_ack: got %b expected 1", g_ack); end
  endtask

  task automatic test_sequential();
    logic [31:0] rpc[3];
    logic [31:0] opc[2];
    logic        otk[2];
    int nr = 0, no = 0;
    for (int i = 0; i < 3; i++) rpc[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin opc[i] = 32'hDEAD_BEEF; otk[i] = 1'bx; end
    do_reset();
    for (int c = 0; c < 20 && (nr < 3 || no < 2); c++) begin
      tick();
      if (g_req_fire && nr < 3) begin rpc[nr] = g_req_pc; nr++; end
      if (g_o_fire && no < 2) begin opc[no] = g_o_pc; otk[no] = g_o_taken; no++; end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rpc[i] !== 32'(4 * i)) begin n_errors++; $display("FAIL seq_req_pc[%0d]: got %h expected %h", i, rpc[i], 32'(4 * i)); end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (opc[i] !== 32'(4 * i) || otk[i] !== 1'b0)
        begin n_errors++; $display("FAIL seq_o_pc[%0d]: got %h/%b expected %h/0", i, opc[i], otk[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_predict();
    bit seen = 0, got_next = 0, got_o = 0;
    logic [31:0] next_pc = 32'hDEAD_BEEF;
    logic        o_tk = 1'bx;
    logic [31:0] exp_next;
    logic        exp_tk;
`ifdef QPU_IFU_BPU_EN
    exp_next = 32'h0000_0008; exp_tk = 1'b1;
`else
    exp_next = 32'h0000_0014; exp_tk = 1'b0;
`endif
    do_reset();
    for (int c = 0; c < 40 && !(got_next && got_o); c++) begin
      tick();
      if (g_o_fire && g_o_pc == 32'h10 && !got_o) begin o_tk = g_o_taken; got_o = 1; end
      if (g_req_fire) begin
        if (!seen && g_req_pc == 32'h10) begin
          seen = 1; k_taken = 1'b1; k_op1 = 32'h0000_0010; k_op2 = 32'hFFFF_FFF8;
        end else if (seen && !got_next) begin
          next_pc = g_req_pc; got_next = 1; k_taken = 1'b0;
        end
      end
    end
    n_checks++; if (next_pc !== exp_next) begin n_errors++; $display("FAIL predict_next_pc: got %h expected %h", next_pc, exp_next); end
    n_checks++; if (o_tk !== exp_tk) begin n_errors++; $display("FAIL predict_o_taken: got %b expected %b", o_tk, exp_tk); end
  endtask

  task automatic test_flush_wait();
    bit found = 0, leaked = 0, done = 0;
    int n_rsp = 0;
    logic [31:0] rpc = 32'hDEAD_BEEF;
    do_reset();
    k_o_ready = 1'b0; k_rsp_delay = 2;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (g_req_fire && g_req_pc == 32'h4) found = 1;
    end
    k_flush = 1'b1; k_flush_pc = 32'h0000_0200;
    tick();
    n_checks++; if (g_o_valid !== 1'b1) begin n_errors++; $display("FAIL flushw_buf_full: got %b expected 1", g_o_valid); end
    k_flush = 1'b0; k_o_ready = 1'b1;
    tick();
    n_checks++; if (g_o_valid !== 1'b0) begin n_errors++; $display("FAIL flushw_o_drop: got %b expected 0", g_o_valid); end
    if (g_rsp_fire) n_rsp++;
    for (int c = 0; c < 20 && !done; c++) begin
      if (g_req_fire) begin rpc = g_req_pc; done = 1; end
      else begin
        tick();
        if (g_o_valid) leaked = 1;
        if (g_rsp_fire) n_rsp++;
      end
    end
    n_checks++; if (rpc !== 32'h200) begin n_errors++; $display("FAIL flushw_req_pc: got %h expected 00000200", rpc); end
    n_checks++; if (n_rsp !== 1 || leaked) begin n_errors++; $display("FAIL flushw_discard: got rsp=%0d leak=%b expected 1/0", n_rsp, leaked); end
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (g_o_valid) done = 1;
    end
    n_checks++; if (g_o_pc !== 32'h200) begin n_errors++; $display("FAIL flushw_o_pc: got %h expected 00000200", g_o_pc); end
  endtask

  task automatic test_flush_fire();
    bit found = 0;
    do_reset();
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (g_req_fire && g_req_pc == 32'h4) found = 1;
    end
    k_flush = 1'b1; k_flush_pc = 32'h0000_0300;
    tick();
    n_checks++; if (g_rsp_fire !== 1'b1) begin n_errors++; $display("FAIL flushf_rsp_fire: got %b expected 1", g_rsp_fire); end
    k_flush = 1'b0;
    tick();
    n_checks++; if (g_req_valid !== 1'b1 || g_req_pc !== 32'h300 || g_o_valid !== 1'b0)
      begin n_errors++; $display("FAIL flushf_req: got v=%b pc=%h ov=%b expected 1/00000300/0", g_req_valid, g_req_pc, g_o_valid); end
    tick();
    tick();
    n_checks++; if (g_o_valid !== 1'b1 || g_o_pc !== 32'h300)
      begin n_errors++; $display("FAIL flushf_no_swallow: got v=%b pc=%h expected 1/00000300", g_o_valid, g_o_pc); end
  endtask

  task automatic test_stall();
    bit found = 0;
    logic [31:0] hpc, hin;
    do_reset();
    k_o_ready = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (g_rsp_valid && g_o_valid) found = 1;
    end
    hpc = g_o_pc; hin = g_o_instr;
    n_checks++; if (hpc !== 32'h0) begin n_errors++; $display("FAIL stall_held_pc: got %h expected 00000000", hpc); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      n_checks++; if (g_rsp_ready !== 1'b0) begin n_errors++; $display("FAIL stall_rsp_ready[%0d]: got %b expected 0", c, g_rsp_ready); end
      n_checks++; if (g_o_pc !== hpc || g_o_instr !== hin || g_o_valid !== 1'b1)
        begin n_errors++; $display("FAIL stall_stable[%0d]: got %h/%h expected %h/%h", c, g_o_pc, g_o_instr, hpc, hin); end
    end
    k_o_ready = 1'b1;
    tick();
    n_checks++; if (g_o_fire !== 1'b1 || g_rsp_fire !== 1'b1)
      begin n_errors++; $display("FAIL stall_release: got ofire=%b rspfire=%b expected 1/1", g_o_fire, g_rsp_fire); end
    tick();
    n_checks++; if (g_o_valid !== 1'b1 || g_o_pc !== hpc + 32'd4)
      begin n_errors++; $display("FAIL stall_next_load: got v=%b pc=%h expected 1/%h", g_o_valid, g_o_pc, hpc + 32'd4); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    k_req_ready = 1'b0; k_flush = 1'b1; k_flush_pc = 32'hFFFF_FFFC; k_o_ready = 1'b0;
    tick();
    k_req_ready = 1'b1; k_flush = 1'b0;
    tick();
    n_checks++; if (g_req_fire !== 1'b1 || g_req_pc !== 32'hFFFF_FFFC)
      begin n_errors++; $display("FAIL wrap_req: got f=%b pc=%h expected 1/fffffffc", g_req_fire, g_req_pc); end
    k_rsp_delay = 3;
    tick();
    tick();
    n_checks++; if (g_req_fire !== 1'b1 || g_req_pc !== 32'h0)
      begin n_errors++; $display("FAIL wrap_next_pc: got f=%b pc=%h expected 1/00000000", g_req_fire, g_req_pc); end
    tick();
    n_checks++; if (g_o_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_buf_full: got %b expected 1", g_o_valid); end
    k_rst = 1'b1;
    tick();
    n_checks++; if (g_req_valid !== 1'b0 || g_rsp_ready !== 1'b0)
      begin n_errors++; $display("FAIL midrst_outputs: got rv=%b rr=%b expected 0/0", g_req_valid, g_rsp_ready); end
    k_rst = 1'b0;
    tick();
    n_checks++; if (g_req_valid !== 1'b1 || g_req_pc !== RST_PC || g_o_valid !== 1'b0)
      begin n_errors++; $display("FAIL midrst_state: got rv=%b pc=%h ov=%b expected 1/%h/0", g_req_valid, g_req_pc, g_o_valid, RST_PC); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      k_rst       = ($urandom_range(0, 299) == 0);
      k_req_ready = ($urandom_range(0, 3) != 0);
      k_o_ready   = ($urandom_range(0, 2) != 0);
      k_flush     = !k_rst && ($urandom_range(0, 11) == 0);
      k_flush_pc  = $urandom & 32'hFFFF_FFFC;
      k_taken     = $urandom_range(0, 1);
      k_op1       = $urandom;
      k_op2       = $urandom & 32'hFFFF_FFFC;
      k_rsp_delay = $urandom_range(0, 3);
      tick();
      n_checks++; if (g_req_valid !== e_req_valid) begin n_errors++; $display("FAIL rnd_req_valid @%0d: got %b expected %b", c, g_req_valid, e_req_valid); end
      if (g_req_valid && e_req_valid) begin
        n_checks++; if (g_req_pc !== e_req_pc) begin n_errors++; $display("FAIL rnd_req_pc @%0d: got %h expected %h", c, g_req_pc, e_req_pc); end
      end
      n_checks++; if (g_rsp_ready !== e_rsp_ready) begin n_errors++; $display("FAIL rnd_rsp_ready @%0d: got %b expected %b", c, g_rsp_ready, e_rsp_ready); end
      n_checks++; if (g_o_valid !== e_o_valid) begin n_errors++; $display("FAIL rnd_o_valid @%0d: got %b expected %b", c, g_o_valid, e_o_valid); end
      if (g_o_valid && e_o_valid) begin
        n_checks++; if ({g_o_pc, g_o_instr, g_o_taken} !== e_o)
          begin n_errors++; $display("FAIL rnd_o_data @%0d: got %h/%h/%b expected %h/%h/%b", c, g_o_pc, g_o_instr, g_o_taken, e_o.pc, e_o.instr, e_o.taken); end
      end
      if (g_rsp_valid && !k_rst) begin
        n_checks++; if (g_bpu_pc !== e_bpu_pc) begin n_errors++; $display("FAIL rnd_bpu_pc @%0d: got %h expected %h", c, g_bpu_pc, e_bpu_pc); end
      end
    end
    k_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_flush_wait();
    test_flush_fire();
    test_stall();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
